dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the pipeline memory stage (core port) and a program/data loader port (ldr port). It issues one access per cycle, returns registered read data, and raises a stall toward the pipeline whenever the core is denied. It sits between the memory stage and the data memory, driving the memory's write enable, funct3, address and write data.

---
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core/loader/memory signal bundle for the data memory arbiter
//
// Purpose: groups the core port, loader port and memory-side signals of
// dmem_arbiter into one bundle.
//   master : environment side (pipeline, loader and memory model)
//   slave  : arbiter side
// Signals:
//   core_*  : pipeline memory-stage request fields, grant, load return and stall
//   ldr_*   : loader request fields, lock, grant and load return
//   mem_*   : single-ported data memory control and data
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  core_req;
  logic                  core_we;
  logic [2:0]            core_funct3;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  stall_m;

  logic                  ldr_req;
  logic                  ldr_we;
  logic [2:0]            ldr_funct3;
  logic [ADDR_WIDTH-1:0] ldr_addr;
  logic [DATA_WIDTH-1:0] ldr_wdata;
  logic                  ldr_lock;
  logic                  ldr_gnt;
  logic                  ldr_rvalid;
  logic [DATA_WIDTH-1:0] ldr_rdata;

  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output core_req, core_we, core_funct3, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, stall_m,
    output ldr_req, ldr_we, ldr_funct3, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_wr_en, mem_funct3, mem_addr, mem_wr_data,
    output mem_rd_data
  );

  modport slave (
    input  core_req, core_we, core_funct3, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, stall_m,
    input  ldr_req, ldr_we, ldr_funct3, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_wr_en, mem_funct3, mem_addr, mem_wr_data,
    input  mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer in front of the single-ported data memory
//
// Purpose: shares the data memory between the pipeline memory stage (core)
// and the program/data loader (ldr). One access per cycle, combinational
// grant, registered load data one cycle after the grant, stall toward the
// pipeline whenever the core is denied.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if slave modport (core port, loader port, memory side)
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    CORE_PRI = 2'd0,
    LDR_PRI  = 2'd1,
    LDR_LOCK = 2'd2
  } arb_state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e            state_q, state_d;
  arb_state_e            arb_state;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  core_gnt;
  logic                  ldr_gnt;
  logic                  core_rvalid_q;
  logic                  ldr_rvalid_q;
  logic [DATA_WIDTH-1:0] core_rdata_q;
  logic [DATA_WIDTH-1:0] ldr_rdata_q;

  // Priority used for this cycle's grant. Reset and a released lock both
  // arbitrate as CORE_PRI so a waiting core is served without a bubble.
  always_comb begin
    arb_state = state_q;
    if (rst || (state_q == LDR_LOCK && !bus.ldr_lock)) begin
      arb_state = CORE_PRI;
    end
  end

  always_comb begin
    core_gnt = 1'b0;
    ldr_gnt  = 1'b0;
    case (arb_state)
      LDR_PRI: begin
        ldr_gnt  = bus.ldr_req;
        core_gnt = bus.core_req & ~bus.ldr_req;
      end
      LDR_LOCK: begin
        ldr_gnt  = bus.ldr_req;
      end
      default: begin
        core_gnt = bus.core_req;
        ldr_gnt  = bus.ldr_req & ~bus.core_req;
      end
    endcase
  end

  // Starvation counter for the loader; saturates so a long wait cannot wrap
  // back below MAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.ldr_req || ldr_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'd15) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = CORE_PRI;
    if (ldr_gnt && bus.ldr_lock) begin
      state_d = LDR_LOCK;
    end else begin
      case (arb_state)
        // Lock still asserted but no request this cycle: keep ownership.
        LDR_LOCK: state_d = LDR_LOCK;
        // A requesting loader is always granted here, so one cycle is enough.
        LDR_PRI:  state_d = CORE_PRI;
        default:  state_d = (wait_cnt_d >= MAX_WAIT_C) ? LDR_PRI : CORE_PRI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CORE_PRI;
      wait_cnt_q    <= 4'd0;
      core_rvalid_q <= 1'b0;
      ldr_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      ldr_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      core_rvalid_q <= core_gnt & ~bus.core_we;
      ldr_rvalid_q  <= ldr_gnt & ~bus.ldr_we;
      if (core_gnt && !bus.core_we) begin
        core_rdata_q <= bus.mem_rd_data;
      end
      if (ldr_gnt && !bus.ldr_we) begin
        ldr_rdata_q <= bus.mem_rd_data;
      end
    end
  end

  // Memory side follows the granted port; everything is zero when idle.
  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_funct3  = 3'd0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    if (core_gnt) begin
      bus.mem_wr_en   = bus.core_we;
      bus.mem_funct3  = bus.core_funct3;
      bus.mem_addr    = bus.core_addr;
      bus.mem_wr_data = bus.core_wdata;
    end else if (ldr_gnt) begin
      bus.mem_wr_en   = bus.ldr_we;
      bus.mem_funct3  = bus.ldr_funct3;
      bus.mem_addr    = bus.ldr_addr;
      bus.mem_wr_data = bus.ldr_wdata;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.ldr_gnt     = ldr_gnt;
  assign bus.stall_m     = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.ldr_rvalid  = ldr_rvalid_q;
  assign bus.ldr_rdata   = ldr_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [0:63];

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_WAIT  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model: combinational read, write at the edge.
  assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bus.core_req    = req;
    bus.core_we     = we;
    bus.core_funct3 = f3;
    bus.core_addr   = addr;
    bus.core_wdata  = wdata;
  endtask

  task automatic ldr_drive(input logic req, input logic we, input logic lock, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.ldr_req    = req;
    bus.ldr_we     = we;
    bus.ldr_lock   = lock;
    bus.ldr_funct3 = f3;
    bus.ldr_addr   = addr;
    bus.ldr_wdata  = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    rst = 1'b1;
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    ldr_drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rvalid", bus.core_rvalid, 0);
    check("rst_ldr_rvalid", bus.ldr_rvalid, 0);
    check("rst_core_rdata", bus.core_rdata, 0);
    check("rst_ldr_rdata", bus.ldr_rdata, 0);
    rst = 1'b0;

    // Core load from 0x10
    core_drive(1, 0, 3'b010, 32'h10, 32'h0);
    #4;
    check("t1_core_gnt", bus.core_gnt, 1);
    check("t1_ldr_gnt", bus.ldr_gnt, 0);
    check("t1_stall", bus.stall_m, 0);
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    check("t1_mem_we", bus.mem_wr_en, 0);
    check("t1_mem_f3", bus.mem_funct3, 3'b010);
    step();
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t1_rvalid", bus.core_rvalid, 1);
    check("t1_rdata", bus.core_rdata, 32'hDEADBEEF);
    check("t1_ldr_rvalid", bus.ldr_rvalid, 0);
    step();
    #4;
    // Idle cycle
    check("idle_rvalid", bus.core_rvalid, 0);
    check("idle_rdata_hold", bus.core_rdata, 32'hDEADBEEF);
    check("idle_mem_we", bus.mem_wr_en, 0);
    check("idle_mem_addr", bus.mem_addr, 0);
    check("idle_mem_wdata", bus.mem_wr_data, 0);
    check("idle_mem_f3", bus.mem_funct3, 0);
    check("idle_core_gnt", bus.core_gnt, 0);
    check("idle_ldr_gnt", bus.ldr_gnt, 0);
    check("idle_stall", bus.stall_m, 0);
    step();

    // Contention: loader gets in on cycle 5 after MAX_WAIT denied cycles
    core_drive(1, 1, 3'b010, 32'h20, 32'h12345678);
    ldr_drive(1, 1, 0, 3'b010, 32'h24, 32'hAAAA5555);
    for (int c = 1; c <= 6; c++) begin
      #4;
      check("t2_core_gnt", bus.core_gnt, (c != 5));
      check("t2_ldr_gnt", bus.ldr_gnt, (c == 5));
      check("t2_stall", bus.stall_m, (c == 5));
      if (c == 5) begin
        check("t2_mem_addr", bus.mem_addr, 32'h24);
        check("t2_mem_wdata", bus.mem_wr_data, 32'hAAAA5555);
        check("t2_mem_we", bus.mem_wr_en, 1);
      end
      step();
      if (c == 5) ldr_drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    end
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t2_store_rvalid", bus.core_rvalid, 0);
    check("t2_ldr_store_rvalid", bus.ldr_rvalid, 0);
    step();

    // Back-to-back: core load 0x24, loader load 0x20, core load 0x10
    core_drive(1, 0, 3'b010, 32'h24, 32'h0);
    #4;
    check("t5_core_gnt_a", bus.core_gnt, 1);
    step();
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    ldr_drive(1, 0, 0, 3'b010, 32'h20, 32'h0);
    #4;
    check("t5_ldr_gnt_b", bus.ldr_gnt, 1);
    check("t5_core_rvalid_b", bus.core_rvalid, 1);
    check("t5_core_rdata_b", bus.core_rdata, 32'hAAAA5555);
    check("t5_ldr_rvalid_b", bus.ldr_rvalid, 0);
    step();
    ldr_drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    core_drive(1, 0, 3'b010, 32'h10, 32'h0);
    #4;
    check("t5_core_gnt_c", bus.core_gnt, 1);
    check("t5_ldr_rvalid_c", bus.ldr_rvalid, 1);
    check("t5_ldr_rdata_c", bus.ldr_rdata, 32'h12345678);
    check("t5_core_rvalid_c", bus.core_rvalid, 0);
    check("t5_core_rdata_c", bus.core_rdata, 32'hAAAA5555);
    step();
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t5_core_rvalid_d", bus.core_rvalid, 1);
    check("t5_core_rdata_d", bus.core_rdata, 32'hDEADBEEF);
    check("t5_ldr_rvalid_d", bus.ldr_rvalid, 0);
    check("t5_ldr_rdata_d", bus.ldr_rdata, 32'h12345678);
    step();

    // Lock: loader takes ownership, then holds it for 3 stores against core_req
    ldr_drive(1, 1, 1, 3'b010, 32'h30, 32'h11110000);
    #4;
    check("t3_ldr_gnt_0", bus.ldr_gnt, 1);
    check("t3_stall_0", bus.stall_m, 0);
    step();
    for (int k = 1; k <= 3; k++) begin
      core_drive(1, 0, 3'b010, 32'h10, 32'h0);
      ldr_drive(1, 1, 1, 3'b010, 32'h30 + 32'(4 * k), 32'h11110000 + 32'(k));
      #4;
      check("t3_stall", bus.stall_m, 1);
      check("t3_core_gnt", bus.core_gnt, 0);
      check("t3_ldr_gnt", bus.ldr_gnt, 1);
      check("t3_mem_we", bus.mem_wr_en, 1);
      check("t3_mem_addr", bus.mem_addr, 32'h30 + 32'(4 * k));
      step();
    end
    ldr_drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t3_unlock_core_gnt", bus.core_gnt, 1);
    check("t3_unlock_stall", bus.stall_m, 0);
    check("t3_unlock_ldr_gnt", bus.ldr_gnt, 0);
    step();
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    ldr_drive(1, 0, 0, 3'b010, 32'h3C, 32'h0);
    #4;
    check("t3_core_rvalid", bus.core_rvalid, 1);
    check("t3_core_rdata", bus.core_rdata, 32'hDEADBEEF);
    check("t3_rb_ldr_gnt", bus.ldr_gnt, 1);
    step();
    ldr_drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t3_rb_ldr_rdata", bus.ldr_rdata, 32'h11110003);
    step();

    // Reset in the middle of a lock, right after a loader load grant
    ldr_drive(1, 1, 1, 3'b010, 32'h40, 32'h00000055);
    #4;
    check("t4_ldr_gnt_0", bus.ldr_gnt, 1);
    step();
    core_drive(1, 0, 3'b010, 32'h10, 32'h0);
    ldr_drive(1, 0, 1, 3'b010, 32'h3C, 32'h0);
    #4;
    check("t4_ldr_gnt_1", bus.ldr_gnt, 1);
    check("t4_stall_1", bus.stall_m, 1);
    step();
    rst = 1'b1;
    #4;
    check("t4_rst_core_gnt", bus.core_gnt, 1);
    check("t4_rst_ldr_gnt", bus.ldr_gnt, 0);
    check("t4_rst_ldr_rvalid", bus.ldr_rvalid, 1);
    step();
    rst = 1'b0;
    ldr_drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t4_core_gnt", bus.core_gnt, 1);
    check("t4_stall", bus.stall_m, 0);
    check("t4_core_rvalid", bus.core_rvalid, 0);
    check("t4_ldr_rvalid", bus.ldr_rvalid, 0);
    check("t4_ldr_rdata", bus.ldr_rdata, 0);
    check("t4_wait_cnt", dut.wait_cnt_q, 0);
    step();
    core_drive(0, 0, 3'd0, 32'h0, 32'h0);
    #4;
    check("t4_post_core_rvalid", bus.core_rvalid, 1);
    check("t4_post_core_rdata", bus.core_rdata, 32'hDEADBEEF);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
